// File: rtl/litspin_drv_pkg.sv
// Shared types and constants for the LED driver scheduling blocks.
// Holds the scheduler state encoding and the grayscale pulse budget.
package litspin_drv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FC_LOAD,
    GS_RUN,
    GS_DONE
  } sched_state_t;

  localparam int NB_COLOURS    = 3;
  localparam int NB_BIT_PLANES = 9;
  localparam int NB_MUX_PASSES = 5;

  // One SCLK rise per colour, LED, bit plane and multiplex pass.
  function automatic int gs_pulses(input int nb_leds_per_group);
    return NB_COLOURS * nb_leds_per_group * NB_BIT_PLANES * NB_MUX_PASSES;
  endfunction

endpackage

// File: rtl/sclk_divider.sv
// Square-wave SCLK generator with CLK_DIV-cycle half-periods. Restart or
// disable parks SCLK low so the next rise is a full half-period away.
module sclk_divider
#(
  parameter int CLK_DIV = 4
)
(
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic restart,
  output logic sclk,
  output logic edge_stb
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (!enable || restart) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // High on the cycle whose closing clk edge would toggle SCLK.
  assign edge_stb = (div_cnt == LAST);

endmodule

// File: rtl/sclk_scheduler.sv
// Sequences function-control writes and grayscale SCLK bursts per rotor angle.
// Optional: define SCHED_OVERRUN_CNT_EN to add the saturating overrun_cnt output.
module sclk_scheduler
  import litspin_drv_pkg::*;
#(
  parameter  int NB_ANGLES         = 128,
  parameter  int NB_LEDS_PER_GROUP = 16,
  parameter  int CLK_DIV           = 4,
  parameter  int FC_BITS           = 48,
  localparam int ANGLE_WIDTH       = $clog2(NB_ANGLES)
)
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ANGLE_WIDTH-1:0] angle,
  input  logic                   fc_req,
  output logic                   fc_ack,
  output logic                   SCLK,
  output logic                   FC_en,
  output logic                   busy,
`ifdef SCHED_OVERRUN_CNT_EN
  output logic                   overrun,
  output logic [15:0]            overrun_cnt
`else
  output logic                   overrun
`endif
);

  localparam int               GS_PULSES = gs_pulses(NB_LEDS_PER_GROUP);
  localparam int               CNT_W     = $clog2(GS_PULSES + 1);
  localparam logic [CNT_W-1:0] GS_LAST   = CNT_W'(GS_PULSES);
  localparam logic [CNT_W-1:0] FC_LAST   = CNT_W'(FC_BITS);

  sched_state_t state, state_next;

  logic [ANGLE_WIDTH-1:0] prev_angle;
  logic [CNT_W-1:0]       pulse_cnt;
  logic                   angle_pending;
  logic                   new_angle;
  logic                   overrun_hit;
  logic                   fc_entry;
  logic                   run_entry;
  logic                   div_enable;
  logic                   div_restart;
  logic                   edge_stb;
  logic                   sclk_rise;

  assign new_angle = (angle != prev_angle);
  assign sclk_rise = edge_stb && !SCLK;

  sclk_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_divider (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (div_enable),
    .restart  (div_restart),
    .sclk     (SCLK),
    .edge_stb (edge_stb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A state ends on the rise that would follow its last pulse, so that
  // pulse keeps its full low half-period and no extra rise escapes.
  always_comb begin
    state_next  = state;
    overrun_hit = 1'b0;
    case (state)
      IDLE, GS_DONE: begin
        if (fc_req) begin
          state_next = FC_LOAD;
        end else if (new_angle || angle_pending) begin
          state_next = GS_RUN;
        end
      end
      FC_LOAD: begin
        if (sclk_rise && (pulse_cnt == FC_LAST)) begin
          state_next = (angle_pending || new_angle) ? GS_RUN : IDLE;
        end
      end
      GS_RUN: begin
        if (new_angle) begin
          overrun_hit = 1'b1;
        end else if (sclk_rise && (pulse_cnt == GS_LAST)) begin
          state_next = GS_DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    FC_en       = (state == FC_LOAD);
    busy        = (state == FC_LOAD) || (state == GS_RUN);
    fc_entry    = (state_next == FC_LOAD) && (state != FC_LOAD);
    run_entry   = (state_next == GS_RUN) && (state != GS_RUN);
    div_enable  = (state_next == FC_LOAD) || (state_next == GS_RUN);
    div_restart = fc_entry || run_entry || overrun_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_angle    <= '0;
      angle_pending <= 1'b0;
      pulse_cnt     <= '0;
      fc_ack        <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      prev_angle <= angle;
      fc_ack     <= fc_entry;
      overrun    <= overrun_hit;
      if (run_entry) begin
        angle_pending <= 1'b0;
      end else if (new_angle && (state_next == FC_LOAD)) begin
        angle_pending <= 1'b1;
      end
      if (div_restart || !div_enable) begin
        pulse_cnt <= '0;
      end else if (sclk_rise) begin
        pulse_cnt <= pulse_cnt + 1'b1;
      end
    end
  end

`ifdef SCHED_OVERRUN_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_cnt <= '0;
    end else if (overrun_hit && (overrun_cnt != 16'hFFFF)) begin
      overrun_cnt <= overrun_cnt + 16'd1;
    end
  end
`else
`endif

endmodule
